// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and the data load/store path.
// Sequences each access over a variable-latency ready handshake, with starvation and timeout bounds.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_LIM = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        DM_WAIT = 2'd2,
        RESP    = 2'd3
    } state_e;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [3:0]        starveCnt_q, starveCnt_d;
    logic [7:0]        waitCnt_q, waitCnt_d;
    logic              isFetch_q, isFetch_d;
    logic              errFlag_q, errFlag_d;
    logic              memWe_q, memWe_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    logic [DATA_W-1:0] ifRdata_q, ifRdata_d;
    logic [DATA_W-1:0] dmRdata_q, dmRdata_d;
    logic              dataReq;
    logic              fetchWins;

    assign dataReq   = dm_rd | dm_wr;
    assign fetchWins = if_req && (!dataReq || (starveCnt_q == STARVE_MAX));

    always_comb begin
        state_d     = state_q;
        starveCnt_d = starveCnt_q;
        waitCnt_d   = waitCnt_q;
        isFetch_d   = isFetch_q;
        errFlag_d   = errFlag_q;
        memWe_d     = memWe_q;
        memAddr_d   = memAddr_q;
        memWdata_d  = memWdata_q;
        ifRdata_d   = ifRdata_q;
        dmRdata_d   = dmRdata_q;
        case (state_q)
            IDLE: begin
                if (!if_req) begin
                    starveCnt_d = '0;
                end
                if (fetchWins) begin
                    state_d     = IF_WAIT;
                    isFetch_d   = 1'b1;
                    memAddr_d   = if_addr;
                    memWe_d     = 1'b0;
                    errFlag_d   = 1'b0;
                    waitCnt_d   = '0;
                    starveCnt_d = '0;
                end else if (dataReq) begin
                    // A simultaneous read+write request is served as a write and flagged as an error.
                    state_d    = DM_WAIT;
                    isFetch_d  = 1'b0;
                    memAddr_d  = dm_addr;
                    memWdata_d = dm_wdata;
                    memWe_d    = dm_wr;
                    errFlag_d  = dm_rd & dm_wr;
                    waitCnt_d  = '0;
                    if (if_req && (starveCnt_q != STARVE_MAX)) begin
                        starveCnt_d = starveCnt_q + 4'd1;
                    end
                end
            end
            IF_WAIT, DM_WAIT: begin
                if (mem_rdy) begin
                    state_d = RESP;
                    if (isFetch_q) begin
                        ifRdata_d = mem_rdata;
                    end else if (!memWe_q) begin
                        dmRdata_d = mem_rdata;
                    end
                end else begin
                    waitCnt_d = waitCnt_q + 8'd1;
                    if (waitCnt_q == WAIT_LAST) begin
                        state_d   = RESP;
                        errFlag_d = 1'b1;
                        if (isFetch_q) begin
                            ifRdata_d = '0;
                        end else if (!memWe_q) begin
                            dmRdata_d = '0;
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            starveCnt_q <= '0;
            waitCnt_q   <= '0;
            isFetch_q   <= 1'b0;
            errFlag_q   <= 1'b0;
            memWe_q     <= 1'b0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            ifRdata_q   <= '0;
            dmRdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            starveCnt_q <= starveCnt_d;
            waitCnt_q   <= waitCnt_d;
            isFetch_q   <= isFetch_d;
            errFlag_q   <= errFlag_d;
            memWe_q     <= memWe_d;
            memAddr_q   <= memAddr_d;
            memWdata_q  <= memWdata_d;
            ifRdata_q   <= ifRdata_d;
            dmRdata_q   <= dmRdata_d;
        end
    end

    assign mem_en    = (state_q == IF_WAIT) || (state_q == DM_WAIT);
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign if_rdata  = ifRdata_q;
    assign dm_rdata  = dmRdata_q;
    assign busy      = (state_q != IDLE);
    assign if_ack    = (state_q == RESP) && isFetch_q;
    assign dm_ack    = (state_q == RESP) && !isFetch_q;
    assign err       = (state_q == RESP) && errFlag_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, arbitration, starvation, timeout, conflict, reset.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        dm_rd;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_ack;
    logic [15:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rdy;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(
        .ADDR_W(16), .DATA_W(16), .STARVE_LIM(4), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge, where inputs are driven and outputs sampled.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++;
        if ({busy, mem_en, mem_we, if_ack, dm_ack, err} !== 6'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags got=%b want=000000", {busy, mem_en, mem_we, if_ack, dm_ack, err});
        end
        total++;
        if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 64'h0) begin
            bad++;
            $display("[TB] FAIL reset_data got=%h want=0", {mem_addr, mem_wdata, if_rdata, dm_rdata});
        end
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();
    endtask

    task automatic test_fetch(input logic [15:0] addr, input logic [15:0] data);
        if_req = 1'b1; if_addr = addr; mem_rdy = 1'b1; mem_rdata = data;
        total++;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL fetch_c0_busy got=%b want=0", busy); end
        nextCycle();
        total++;
        if ({mem_en, mem_we, if_ack, busy} !== 4'b1001) begin
            bad++; $display("[TB] FAIL fetch_c1_ctl got=%b want=1001", {mem_en, mem_we, if_ack, busy});
        end
        total++;
        if (mem_addr !== addr) begin bad++; $display("[TB] FAIL fetch_c1_addr got=%h want=%h", mem_addr, addr); end
        nextCycle();
        total++;
        if ({if_ack, dm_ack, mem_en, err} !== 4'b1000) begin
            bad++; $display("[TB] FAIL fetch_c2_ack got=%b want=1000", {if_ack, dm_ack, mem_en, err});
        end
        total++;
        if (if_rdata !== data) begin bad++; $display("[TB] FAIL fetch_c2_rdata got=%h want=%h", if_rdata, data); end
        if_req = 1'b0;
        nextCycle();
        total++;
        if ({busy, if_ack, mem_en} !== 3'b000) begin
            bad++; $display("[TB] FAIL fetch_c3_idle got=%b want=000", {busy, if_ack, mem_en});
        end
    endtask

    task automatic test_priority();
        if_req = 1'b1; if_addr = 16'h0200; dm_rd = 1'b1; dm_addr = 16'h0100;
        mem_rdy = 1'b1; mem_rdata = 16'h1111;
        nextCycle();
        total++;
        if (mem_addr !== 16'h0100 || mem_en !== 1'b1) begin
            bad++; $display("[TB] FAIL prio_c1_data_first got addr=%h en=%b want addr=0100 en=1", mem_addr, mem_en);
        end
        nextCycle();
        total++;
        if ({dm_ack, if_ack} !== 2'b10 || dm_rdata !== 16'h1111) begin
            bad++; $display("[TB] FAIL prio_c2_dm_ack got ack=%b rdata=%h want ack=10 rdata=1111", {dm_ack, if_ack}, dm_rdata);
        end
        dm_rd = 1'b0; mem_rdata = 16'h2222;
        nextCycle();
        total++;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL prio_c3_idle got busy=%b want 0", busy); end
        nextCycle();
        total++;
        if (mem_addr !== 16'h0200 || mem_en !== 1'b1) begin
            bad++; $display("[TB] FAIL prio_c4_fetch got addr=%h en=%b want addr=0200 en=1", mem_addr, mem_en);
        end
        nextCycle();
        total++;
        if (if_ack !== 1'b1 || if_rdata !== 16'h2222 || dm_rdata !== 16'h1111) begin
            bad++; $display("[TB] FAIL prio_c5_if_ack got ack=%b if_rdata=%h dm_rdata=%h want 1 2222 1111", if_ack, if_rdata, dm_rdata);
        end
        if_req = 1'b0;
        nextCycle();
    endtask

    task automatic test_starve();
        logic [9:0] ev;
        int n = 0;
        int writes = 0;
        ev = '0;
        if_req = 1'b1; if_addr = 16'h0300; dm_wr = 1'b1; dm_addr = 16'h0700; dm_wdata = 16'h00AA;
        mem_rdy = 1'b1; mem_rdata = 16'h3C3C;
        for (int i = 0; i < 60 && n < 10; i++) begin
            nextCycle();
            if (mem_en && mem_we) writes++;
            if (dm_ack) begin
                ev[n] = 1'b0; n++;
            end else if (if_ack) begin
                ev[n] = 1'b1; n++;
            end
        end
        if_req = 1'b0; dm_wr = 1'b0;
        total++;
        if (n !== 10) begin bad++; $display("[TB] FAIL starve_events got=%0d want=10", n); end
        total++;
        if (ev !== 10'b10000_10000) begin bad++; $display("[TB] FAIL starve_order got=%b want=1000010000", ev); end
        total++;
        if (writes !== 8) begin bad++; $display("[TB] FAIL starve_writes got=%0d want=8", writes); end
        total++;
        if (if_rdata !== 16'h3C3C) begin bad++; $display("[TB] FAIL starve_if_rdata got=%h want=3c3c", if_rdata); end
        nextCycle();
        total++;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL starve_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_timeout();
        int enCnt = 0;
        bit got = 0;
        dm_rd = 1'b1; dm_addr = 16'h0400; mem_rdy = 1'b0; mem_rdata = 16'hFFFF;
        for (int i = 0; i < 40 && !got; i++) begin
            nextCycle();
            if (dm_ack) got = 1;
            else if (mem_en) enCnt++;
        end
        total++;
        if (got !== 1'b1) begin bad++; $display("[TB] FAIL timeout_ack got=%b want=1 (no ack within 40 cycles)", got); end
        total++;
        if (enCnt !== 15) begin bad++; $display("[TB] FAIL timeout_en_cycles got=%0d want=15", enCnt); end
        total++;
        if ({err, mem_en} !== 2'b10 || dm_rdata !== 16'h0000) begin
            bad++; $display("[TB] FAIL timeout_resp got err=%b en=%b rdata=%h want err=1 en=0 rdata=0000", err, mem_en, dm_rdata);
        end
        dm_rd = 1'b0;
        nextCycle();
        total++;
        if ({busy, err, dm_ack} !== 3'b000) begin
            bad++; $display("[TB] FAIL timeout_idle got=%b want=000", {busy, err, dm_ack});
        end
    endtask

    task automatic test_conflict();
        dm_rd = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0500; dm_wdata = 16'h1234;
        mem_rdy = 1'b1; mem_rdata = 16'h7777;
        nextCycle();
        total++;
        if ({mem_en, mem_we, err} !== 3'b110 || mem_wdata !== 16'h1234 || mem_addr !== 16'h0500) begin
            bad++; $display("[TB] FAIL conflict_c1 got en/we/err=%b wdata=%h addr=%h want 110 1234 0500", {mem_en, mem_we, err}, mem_wdata, mem_addr);
        end
        nextCycle();
        total++;
        if ({dm_ack, err} !== 2'b11) begin bad++; $display("[TB] FAIL conflict_c2_ack_err got=%b want=11", {dm_ack, err}); end
        total++;
        if (dm_rdata !== 16'h0000) begin bad++; $display("[TB] FAIL conflict_c2_rdata got=%h want=0000", dm_rdata); end
        dm_rd = 1'b0; dm_wr = 1'b0;
        nextCycle();
        total++;
        if ({busy, err} !== 2'b00) begin bad++; $display("[TB] FAIL conflict_c3_idle got=%b want=00", {busy, err}); end
    endtask

    task automatic test_reset_mid();
        int ackSeen = 0;
        dm_rd = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0600; mem_rdy = 1'b0;
        nextCycle();
        total++;
        if (mem_en !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_wait got en=%b want 1", mem_en); end
        nextCycle();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({mem_en, busy, dm_ack, err, mem_we} !== 5'b0 || {mem_addr, if_rdata, dm_rdata} !== 48'h0) begin
            bad++; $display("[TB] FAIL rstmid_clear got ctl=%b addr=%h if_rdata=%h want all 0", {mem_en, busy, dm_ack, err, mem_we}, mem_addr, if_rdata);
        end
        dm_rd = 1'b0;
        for (int i = 0; i < 2; i++) begin
            nextCycle();
            if (dm_ack) ackSeen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            nextCycle();
            if (dm_ack) ackSeen++;
        end
        total++;
        if (ackSeen !== 0) begin bad++; $display("[TB] FAIL rstmid_no_ack got=%0d want=0", ackSeen); end
        test_fetch(16'h0040, 16'hA5A5);
    endtask

    initial begin
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; dm_rd = 1'b0; dm_wr = 1'b0;
        dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_rdy = 1'b0;
        #2;
        test_reset();
        test_fetch(16'h0040, 16'hA5A5);
        test_priority();
        test_starve();
        test_timeout();
        test_conflict();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
